// File: rtl/sysbus_pkg.sv
// Shared Sysbus types: request/response tag layout, tag constants and the client priv encoding.
package sysbus_pkg;

  typedef struct packed {
    logic       wr;
    logic [3:0] t;
    logic [7:0] priv;
  } tag_t;

  localparam logic       READ   = 1'b0;
  localparam logic       WRITE  = 1'b1;
  localparam logic [3:0] MEMORY = 4'b0001;

  // Client i is identified on the bus by a one-hot priv starting at bit 1.
  function automatic logic [7:0] PRIV(input int unsigned i);
    PRIV = 8'h01 << (i + 1);
  endfunction

endpackage

// File: rtl/sysbus_line_arbiter_rr_pick.sv
// rr_pick: one-hot grant to the first requester at or after ptr (ptr=0 gives fixed priority).
// Latency: combinational.
// Backpressure: none; grant is a pure function of req and ptr.
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_gnt;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot_req = N'({req, req} >> ptr);
  assign rot_gnt = rot_req & (~rot_req + N'(1));
  assign gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);

endmodule

// File: rtl/sysbus_line_arbiter.sv
// sysbus_line_arbiter: N-client whole-line arbiter onto Sysbus, one transaction outstanding; ARB_ROUND_ROBIN_EN selects round-robin.
// Latency: write done 1 cycle after the last data ack; read done 1 cycle after the last response beat.
// Backpressure: each request beat held until bus_reqack; responses are always accepted (bus_respack = bus_respcyc).
module sysbus_line_arbiter
  import sysbus_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int LINE_BITS   = 512,
  parameter int BUS_W       = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLIENTS-1:0]         cli_req,
  input  logic [NUM_CLIENTS-1:0]         cli_wr,
  input  logic [NUM_CLIENTS*64-1:0]      cli_addr,
  input  logic [NUM_CLIENTS*LINE_BITS-1:0] cli_wdata,
  output logic [LINE_BITS-1:0]           cli_rdata,
  output logic [NUM_CLIENTS-1:0]         cli_done,
  output logic                           bus_reqcyc,
  output logic [BUS_W-1:0]               bus_req,
  output logic [12:0]                    bus_reqtag,
  input  logic                           bus_reqack,
  input  logic                           bus_respcyc,
  input  logic [BUS_W-1:0]               bus_resp,
  input  logic [12:0]                    bus_resptag,
  output logic                           bus_respack,
  output logic                           resp_err
);

  localparam int BEATS = LINE_BITS / BUS_W;
  localparam int BC_W  = $clog2(BEATS) + 1;
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             state;
  logic [BC_W-1:0]        beat_cnt;
  logic [NUM_CLIENTS-1:0] cur_gnt;
  logic                   cur_wr;
  logic [63:0]            cur_addr;
  logic [LINE_BITS-1:0]   cur_wdata;
  logic [LINE_BITS-1:0]   line;
  logic [7:0]             cur_priv;

  logic [NUM_CLIENTS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_ptr;
  logic                   sel_wr;
  logic [63:0]            sel_addr;
  logic [LINE_BITS-1:0]   sel_wdata;
  logic [7:0]             sel_priv;

  tag_t                   req_tag;
  tag_t                   resp_tag;
  logic                   resp_match;
  logic                   last_beat;
  logic                   unused_resp_t;

  rr_pick #(.N(NUM_CLIENTS), .PTR_W(IDX_W)) u_pick (
    .req (cli_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_priv  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_gnt[i]) begin
        sel_wr    = cli_wr[i];
        sel_addr  = cli_addr[i*64 +: 64];
        sel_wdata = cli_wdata[i*LINE_BITS +: LINE_BITS];
        sel_priv  = PRIV(i);
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  assign pick_ptr = rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == S_IDLE && |cli_req) begin
      rr_ptr <= (pick_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end
`else
  assign pick_ptr = '0;
`endif

  assign resp_tag      = tag_t'(bus_resptag);
  assign unused_resp_t = ^resp_tag.t;
  assign resp_match    = bus_respcyc && (state == S_RWAIT) &&
                         (resp_tag.priv == cur_priv) && (resp_tag.wr == READ);
  assign last_beat     = (beat_cnt == BC_W'(BEATS - 1));

  assign req_tag     = '{wr: cur_wr, t: MEMORY, priv: cur_priv};
  assign bus_reqcyc  = (state == S_ADDR) || (state == S_WDATA);
  assign bus_reqtag  = bus_reqcyc ? req_tag : '0;
  assign bus_respack = bus_respcyc;
  assign cli_done    = (state == S_DONE) ? cur_gnt : '0;
  assign cli_rdata   = (state == S_DONE && cur_wr == READ) ? line : '0;

  always_comb begin
    bus_req = '0;
    if (state == S_ADDR)       bus_req = BUS_W'(cur_addr);
    else if (state == S_WDATA) bus_req = cur_wdata[BUS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      cur_gnt   <= '0;
      cur_wr    <= READ;
      cur_addr  <= '0;
      cur_wdata <= '0;
      line      <= '0;
      cur_priv  <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|cli_req) begin
            cur_gnt   <= pick_gnt;
            cur_wr    <= (sel_wr == WRITE) ? WRITE : READ;
            cur_addr  <= sel_addr;
            cur_wdata <= sel_wdata;
            cur_priv  <= sel_priv;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_reqack) begin
            beat_cnt <= '0;
            state    <= (cur_wr == WRITE) ? S_WDATA : S_RWAIT;
          end
        end
        S_WDATA: begin
          // Data beats are drained from the bottom of the latched line.
          if (bus_reqack) begin
            cur_wdata <= cur_wdata >> BUS_W;
            beat_cnt  <= beat_cnt + BC_W'(1);
            if (last_beat) state <= S_DONE;
          end
        end
        S_RWAIT: begin
          if (resp_match) begin
            line     <= {bus_resp, line[LINE_BITS-1:BUS_W]};
            beat_cnt <= beat_cnt + BC_W'(1);
            if (last_beat) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (bus_respcyc && !resp_match) resp_err <= 1'b1;
    end
  end

endmodule
